// File: rtl/wb_sram_bist_master_pkg.sv
// Shared types and constants for the SRAM BIST Wishbone initiator.
package wb_sram_bist_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    DONE,
    TOUT
  } bist_state_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int tout_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_sram_bist_master_if.sv
// Wishbone initiator/responder signal bundle used between the BIST master and the SRAM responder.
interface wb_sram_bist_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_master_xfer.sv
// Single-request Wishbone engine: raises cyc/stb on req, holds the request
// stable until ack or timeout, then drops stb so the next cycle is the gap.
module wb_master_xfer
  import wb_sram_bist_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        done_o,
  output logic [31:0] rdat_o,
  output logic        tout_o,
  wb_sram_bist_master_if.master wb
);

  localparam int CW = tout_cnt_w(TIMEOUT);

  logic [CW-1:0] wait_cnt;

  // Completion is reported in the ack cycle so the sequencer can issue the
  // next request exactly one gap cycle later.
  assign done_o = wb.wbm_stb_o & wb.wbm_ack_i;
  assign rdat_o = wb.wbm_dat_i;
  assign tout_o = wb.wbm_stb_o & ~wb.wbm_ack_i & (wait_cnt == CW'(TIMEOUT));

  // Bus request register and wait counter; ack in the TIMEOUT cycle still wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
      wb.wbm_we_o  <= 1'b0;
      wb.wbm_sel_o <= '0;
      wb.wbm_adr_o <= '0;
      wb.wbm_dat_o <= '0;
      wait_cnt     <= '0;
    end else if (wb.wbm_stb_o) begin
      if (wb.wbm_ack_i || tout_o) begin
        wb.wbm_cyc_o <= 1'b0;
        wb.wbm_stb_o <= 1'b0;
        wb.wbm_sel_o <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else if (req_i) begin
      wb.wbm_cyc_o <= 1'b1;
      wb.wbm_stb_o <= 1'b1;
      wb.wbm_we_o  <= we_i;
      wb.wbm_sel_o <= SEL_ALL;
      wb.wbm_adr_o <= adr_i;
      wb.wbm_dat_o <= wdat_i;
      wait_cnt     <= '0;
    end
  end

endmodule

// File: rtl/wb_sram_bist_master.sv
// SRAM BIST sequencer: writes seed^idx over 0..last, reads it back, compares
// each word and reports pass/fail, error count, first failure and timeout.
module wb_sram_bist_master
  import wb_sram_bist_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h30c0_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          TIMEOUT    = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  start_i,
  input  logic [31:0]           seed_i,
  input  logic [ADDR_WIDTH-1:0] last_idx_i,
  wb_sram_bist_master_if.master wbm,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] fail_idx_o,
  output logic [31:0]           fail_dat_o
);

  bist_state_e           state;
  logic [ADDR_WIDTH-1:0] idx_r, last_r;
  logic [31:0]           seed_r;

  logic                  req;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           req_seed;
  logic                  x_done, x_tout;
  logic [31:0]           x_rdat;
  logic                  mismatch;

  // Next request is decided in IDLE (start) and in the gap states so stb
  // rises on the same edge the FSM leaves them.
  always_comb begin
    req      = 1'b0;
    req_we   = 1'b1;
    req_idx  = idx_r;
    req_seed = seed_r;
    case (state)
      IDLE: if (start_i) begin
        req      = 1'b1;
        req_idx  = '0;
        req_seed = seed_i;
      end
      WR_GAP: begin
        req = 1'b1;
        if (idx_r == last_r) begin
          req_we  = 1'b0;
          req_idx = '0;
        end else begin
          req_idx = idx_r + 1'b1;
        end
      end
      RD_GAP: if (idx_r != last_r) begin
        req     = 1'b1;
        req_we  = 1'b0;
        req_idx = idx_r + 1'b1;
      end
      default: ;
    endcase
  end

  wb_master_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .req_i     (req),
    .we_i      (req_we),
    .adr_i     (BASE_ADDR | 32'(req_idx)),
    .wdat_i    (req_seed ^ 32'(req_idx)),
    .done_o    (x_done),
    .rdat_o    (x_rdat),
    .tout_o    (x_tout),
    .wb        (wbm)
  );

  // Full-width compare of read data against the expected pattern.
  assign mismatch = (x_rdat != (seed_r ^ 32'(idx_r)));

  // Test sequencer with registered status outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      idx_r      <= '0;
      last_r     <= '0;
      seed_r     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      timeout_o  <= 1'b0;
      err_cnt_o  <= '0;
      fail_idx_o <= '0;
      fail_dat_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state      <= WR_REQ;
          idx_r      <= '0;
          seed_r     <= seed_i;
          last_r     <= last_idx_i;
          err_cnt_o  <= '0;
          fail_idx_o <= '0;
          fail_dat_o <= '0;
          done_o     <= 1'b0;
          pass_o     <= 1'b0;
          timeout_o  <= 1'b0;
          busy_o     <= 1'b1;
        end
        WR_REQ: begin
          if (x_done) begin
            state <= WR_GAP;
          end else if (x_tout) begin
            state     <= TOUT;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
          end
        end
        WR_GAP: begin
          if (idx_r == last_r) begin
            state <= RD_REQ;
            idx_r <= '0;
          end else begin
            state <= WR_REQ;
            idx_r <= idx_r + 1'b1;
          end
        end
        RD_REQ: begin
          if (x_done) begin
            state <= RD_GAP;
            if (mismatch) begin
              if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
              if (err_cnt_o == 16'd0) begin
                fail_idx_o <= idx_r;
                fail_dat_o <= x_rdat;
              end
            end
          end else if (x_tout) begin
            state     <= TOUT;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
          end
        end
        RD_GAP: begin
          if (idx_r == last_r) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_cnt_o == 16'd0);
          end else begin
            state <= RD_REQ;
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        TOUT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bist_master.sv
// Directed bench for the SRAM BIST master with a 2-cycle-ack SRAM responder model.
module tb_wb_sram_bist_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [7:0]  last = '0;
  logic        busy, done, pass, tout;
  logic [15:0] err_cnt;
  logic [7:0]  fail_idx;
  logic [31:0] fail_dat;

  wb_sram_bist_master_if bus();

  wb_sram_bist_master dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .start_i    (start),
    .seed_i     (seed),
    .last_idx_i (last),
    .wbm        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .timeout_o  (tout),
    .err_cnt_o  (err_cnt),
    .fail_idx_o (fail_idx),
    .fail_dat_o (fail_dat)
  );

  always #5 clk = ~clk;

  // responder model
  logic [31:0] mem [0:255];
  logic        r_ack;
  logic [31:0] r_dat;
  logic [1:0]  dly;
  logic        no_ack = 1'b0;
  logic        corrupt = 1'b0;
  logic        spur_ack = 1'b0;

  assign bus.wbm_ack_i = r_ack | spur_ack;
  assign bus.wbm_dat_i = r_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      dly   <= '0;
    end else if (bus.wbm_stb_o && !r_ack && !no_ack) begin
      if (dly == 2'd1) begin
        r_ack <= 1'b1;
        dly   <= '0;
        if (bus.wbm_we_o) mem[bus.wbm_adr_o[7:0]] <= bus.wbm_dat_o;
        else if (corrupt && (bus.wbm_adr_o[7:0] == 8'd2 || bus.wbm_adr_o[7:0] == 8'd3)) r_dat <= '0;
        else r_dat <= mem[bus.wbm_adr_o[7:0]];
      end else begin
        dly <= dly + 2'd1;
      end
    end else begin
      r_ack <= 1'b0;
      dly   <= '0;
    end
  end

  // transfer log and gap monitor, cleared whenever run_id changes
  int          run_id = 0;
  int          mon_id = 0;
  int          wr_n, rd_n, n_gaps, gap_bad, low_run;
  bit          seen_pulse;
  logic [31:0] wr_adr [0:15];
  logic [31:0] wr_dat [0:15];

  always @(negedge clk) begin
    if (mon_id != run_id) begin
      mon_id = run_id;
      wr_n = 0; rd_n = 0; n_gaps = 0; gap_bad = 0; low_run = 0; seen_pulse = 0;
    end
    if (bus.wbm_stb_o && bus.wbm_ack_i) begin
      if (bus.wbm_we_o) begin
        if (wr_n < 16) begin
          wr_adr[wr_n] = bus.wbm_adr_o;
          wr_dat[wr_n] = bus.wbm_dat_o;
        end
        wr_n++;
      end else begin
        rd_n++;
      end
    end
    if (bus.wbm_stb_o) begin
      if (seen_pulse && low_run != 0) begin
        n_gaps++;
        if (low_run != 1) gap_bad++;
      end
      low_run = 0;
      seen_pulse = 1;
    end else if (seen_pulse) begin
      low_run++;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] s, input logic [7:0] l);
    @(negedge clk);
    run_id++;
    seed  = s;
    last  = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_cyc",  {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("rst_stb",  {31'd0, bus.wbm_stb_o}, 32'd0);
    chk("rst_sel",  {28'd0, bus.wbm_sel_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err",  {16'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean run, 4 words
    start_run(32'hA5A5_0000, 8'd3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1_done");
    chk("t1_pass", {31'd0, pass}, 32'd1);
    chk("t1_err",  {16'd0, err_cnt}, 32'd0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_tout", {31'd0, tout}, 32'd0);
    chk("t1_wr_n", wr_n, 32'd4);
    chk("t1_rd_n", rd_n, 32'd4);
    chk("t1_adr0", wr_adr[0], 32'h30c0_0000);
    chk("t1_adr3", wr_adr[3], 32'h30c0_0003);
    chk("t1_dat0", wr_dat[0], 32'hA5A5_0000);
    chk("t1_dat2", wr_dat[2], 32'hA5A5_0002);
    chk("t1_dat3", wr_dat[3], 32'hA5A5_0003);
    chk("t1_gaps", n_gaps, 32'd7);
    chk("t1_gapbad", gap_bad, 32'd0);

    // corrupted reads at idx 2 and 3
    corrupt = 1'b1;
    start_run(32'hA5A5_0000, 8'd3);
    wait_done("t2_done");
    corrupt = 1'b0;
    chk("t2_err",      {16'd0, err_cnt}, 32'd2);
    chk("t2_fail_idx", {24'd0, fail_idx}, 32'd2);
    chk("t2_fail_dat", fail_dat, 32'h0);
    chk("t2_pass",     {31'd0, pass}, 32'd0);

    // no ack on first write: stb up on the start edge, drops 17 edges later
    no_ack = 1'b1;
    @(negedge clk);
    run_id++;
    seed = 32'h1234_0000; last = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_cyc_e0", {31'd0, bus.wbm_cyc_o}, 32'd1);
    repeat (16) @(posedge clk);
    #1;
    chk("t3_cyc_e16", {31'd0, bus.wbm_cyc_o}, 32'd1);
    @(posedge clk); #1;
    chk("t3_cyc_e17", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("t3_tout", {31'd0, tout}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_pass", {31'd0, pass}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    no_ack = 1'b0;
    repeat (3) @(negedge clk);

    // single word
    start_run(32'h0F0F_F0F0, 8'd0);
    wait_done("t4_done");
    chk("t4_wr_n", wr_n, 32'd1);
    chk("t4_rd_n", rd_n, 32'd1);
    chk("t4_gaps", n_gaps, 32'd1);
    chk("t4_gapbad", gap_bad, 32'd0);
    chk("t4_pass", {31'd0, pass}, 32'd1);
    chk("t4_dat0", wr_dat[0], 32'h0F0F_F0F0);

    // reset during a read strobe, then a clean rerun
    start_run(32'hCAFE_0000, 8'd3);
    for (int i = 0; i < 200 && !(bus.wbm_stb_o && !bus.wbm_we_o); i++) @(negedge clk);
    chk("t5_in_read", {31'd0, bus.wbm_stb_o && !bus.wbm_we_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("t5_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(32'hCAFE_0000, 8'd3);
    wait_done("t5_done");
    chk("t5_pass", {31'd0, pass}, 32'd1);
    chk("t5_wr_n", wr_n, 32'd4);

    // start while busy and spurious ack in a gap are both ignored
    start_run(32'h5A5A_1111, 8'd3);
    repeat (5) @(negedge clk);
    seed = 32'hFFFF_FFFF; last = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(busy && !bus.wbm_stb_o); i++) @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    wait_done("t6_done");
    chk("t6_wr_n", wr_n, 32'd4);
    chk("t6_rd_n", rd_n, 32'd4);
    chk("t6_pass", {31'd0, pass}, 32'd1);
    chk("t6_err",  {16'd0, err_cnt}, 32'd0);
    chk("t6_dat1", wr_dat[1], 32'h5A5A_1110);
    chk("t6_gapbad", gap_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // hard stop in case a wait above misbehaves
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
